// File: rtl/spi_pwm_host_if.sv
// Command/response handshake between a host-side user and the spi_pwm_host SPI master.
// master = command source, slave = spi_pwm_host.
interface spi_pwm_host_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [1:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, resp_valid, resp_data, resp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, resp_valid, resp_data, resp_err, busy
    );
endinterface

// File: rtl/spi_pwm_host.sv
// SPI mode-0 master for the 4-channel PWM driver: turns read/write-level commands into byte frames.
// Optional SPI_PWM_WRITE_VERIFY_EN: writes get a third byte and the echoed level is compared with wdata.
module spi_pwm_host #(
    parameter int CLK_DIV = 8,   // clk cycles per sclk half-period, 4..255
    parameter int CS_GAP  = 2    // sclk half-periods of cs_n setup/hold/gap, >= 1
) (
    input  logic           clk,
    input  logic           reset_n,
    spi_pwm_host_if.slave  host_if,
    output logic           sclk,
    output logic           cs_n,
    output logic           mosi,
    input  logic           miso
);

`ifdef SPI_PWM_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    localparam int CNT_W   = 16;
    localparam int GAP_CYC = CS_GAP * CLK_DIV;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_CS_HOLD,
        ST_CS_GAP
    } state_t;

    state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0] bit_q;
    logic [1:0] byte_q;
    logic       final_q;
    logic       wr_q;
    logic [1:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rx_q;
    logic       sclk_q;
    logic       cs_n_q;
    logic       mosi_q;
    logic       ready_q;
    logic       resp_valid_q;
    logic [7:0] resp_data_q;
    logic       resp_err_q;
    logic       busy_q;
    logic       miso_s1_q;
    logic       miso_s2_q;

    logic [2:0] bit_d;
    logic [1:0] byte_d;
    logic [1:0] last_byte_d;
    logic [7:0] tx_cur_d;
    logic [7:0] tx_nxt_d;

    function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic wr,
                                           input logic [1:0] addr, input logic [7:0] wdata);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0:    b = {wr, 5'b00000, addr};
            2'd1:    b = wr ? wdata : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        bit_d       = bit_q + 3'd1;
        byte_d      = (bit_q == 3'd7) ? byte_q + 2'd1 : byte_q;
        last_byte_d = (wr_q && VERIFY) ? 2'd2 : 2'd1;
        tx_cur_d    = tx_byte(byte_q, wr_q, addr_q, wdata_q);
        tx_nxt_d    = tx_byte(byte_d, wr_q, addr_q, wdata_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            byte_q       <= 2'd0;
            final_q      <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 2'd0;
            wdata_q      <= 8'h00;
            rx_q         <= 8'h00;
            sclk_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ready_q && host_if.cmd_valid) begin
                        wr_q    <= host_if.cmd_write;
                        addr_q  <= host_if.cmd_addr;
                        wdata_q <= host_if.cmd_wdata;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cs_n_q  <= 1'b0;
                        bit_q   <= 3'd0;
                        byte_q  <= 2'd0;
                        final_q <= 1'b0;
                        rx_q    <= 8'h00;
                        cnt_q   <= CNT_W'(GAP_CYC - 1);
                        state_q <= ST_CS_SETUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                ST_CS_SETUP: begin
                    if (cnt_q == '0) begin
                        mosi_q  <= tx_cur_d[~bit_q];
                        cnt_q   <= CNT_W'(CLK_DIV - 1);
                        state_q <= ST_SHIFT_LO;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_SHIFT_LO: begin
                    if (cnt_q == '0) begin
                        if (final_q) begin
                            cnt_q   <= CNT_W'(GAP_CYC - 1);
                            state_q <= ST_CS_HOLD;
                        end else begin
                            // miso is captured as sclk rises; only the last byte carries data back
                            if (byte_q == last_byte_d)
                                rx_q[bit_q] <= miso_s2_q;
                            sclk_q  <= 1'b1;
                            cnt_q   <= CNT_W'(CLK_DIV - 1);
                            state_q <= ST_SHIFT_HI;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_SHIFT_HI: begin
                    if (cnt_q == '0) begin
                        sclk_q  <= 1'b0;
                        cnt_q   <= CNT_W'(CLK_DIV - 1);
                        state_q <= ST_SHIFT_LO;
                        // the trailing low phase gives the driver the falling edge it commits on
                        if (bit_q == 3'd7 && byte_q == last_byte_d) begin
                            final_q <= 1'b1;
                            mosi_q  <= 1'b0;
                        end else begin
                            bit_q  <= bit_d;
                            byte_q <= byte_d;
                            mosi_q <= tx_nxt_d[~bit_d];
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_CS_HOLD: begin
                    if (cnt_q == '0) begin
                        cs_n_q       <= 1'b1;
                        final_q      <= 1'b0;
                        busy_q       <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= (wr_q && !VERIFY) ? wdata_q : rx_q;
                        resp_err_q   <= VERIFY && wr_q && (rx_q != wdata_q);
                        // one cycle less here because IDLE spends one cycle with cs_n still high
                        cnt_q        <= CNT_W'(GAP_CYC - 2);
                        state_q      <= ST_CS_GAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_CS_GAP: begin
                    if (cnt_q == '0) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    mosi_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sclk               = sclk_q;
    assign cs_n               = cs_n_q;
    assign mosi               = mosi_q;
    assign host_if.cmd_ready  = ready_q;
    assign host_if.resp_valid = resp_valid_q;
    assign host_if.resp_data  = resp_data_q;
    assign host_if.resp_err   = resp_err_q;
    assign host_if.busy       = busy_q;

endmodule

// File: tb/tb_spi_pwm_host.sv
// Directed bench for spi_pwm_host against a behavioural model of the 4-channel PWM driver.
// Build with +define+SPI_PWM_WRITE_VERIFY_EN to exercise the 3-byte verified write.
module tb_spi_pwm_host;

    localparam int CLK_DIV = 8;
    localparam int CS_GAP  = 2;
`ifdef SPI_PWM_WRITE_VERIFY_EN
    localparam int WR_BYTES = 3;
`else
    localparam int WR_BYTES = 2;
`endif
    localparam int WR_BUSY = (2*CS_GAP + 16*WR_BYTES + 1) * CLK_DIV;
    localparam int RD_BUSY = (2*CS_GAP + 16*2 + 1) * CLK_DIV;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sclk, cs_n, mosi, miso;
    logic force_zero = 1'b0;

    spi_pwm_host_if hif ();

    spi_pwm_host #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .host_if (hif),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso)
    );

    always #5 clk = ~clk;

    // ---------------- driver model ----------------
    logic [7:0] lvl [0:3] = '{default: 8'h00};
    logic [7:0] mb  [0:2] = '{default: 8'h00};
    int   bitc = 0;
    int   rise_tot = 0;
    int   fall_tot = 0;
    int   hi_run = 0;
    int   hi_last = 0;
    logic sclk_p = 1'b0;
    logic cs_p = 1'b1;
    logic miso_m = 1'b0;

    assign miso = force_zero ? 1'b0 : miso_m;

    always @(posedge clk) begin
        sclk_p <= sclk;
        cs_p   <= cs_n;
        if (cs_p && !cs_n) begin
            bitc    <= 0;
            mb[0]   <= 8'h00;
            mb[1]   <= 8'h00;
            mb[2]   <= 8'h00;
            hi_last <= hi_run;
            hi_run  <= 0;
        end else if (cs_n) begin
            hi_run <= hi_run + 1;
        end
        if (!cs_n && !sclk_p && sclk) begin
            rise_tot <= rise_tot + 1;
            if (bitc < 24)
                mb[bitc/8] <= {mb[bitc/8][6:0], mosi};
            bitc <= bitc + 1;
        end
        if (!cs_n && sclk_p && !sclk) begin
            fall_tot <= fall_tot + 1;
            if (bitc == 16 && mb[0][7])
                lvl[mb[0][1:0]] <= mb[1];
            if (bitc >= 8 && bitc < 16 && !mb[0][7])
                miso_m <= lvl[mb[0][1:0]][3'(bitc - 8)];
            else if (bitc >= 16 && bitc < 24 && mb[0][7])
                miso_m <= mb[1][3'(bitc - 16)];
            else
                miso_m <= 1'b0;
        end
        if (cs_n)
            miso_m <= 1'b0;
    end

    // ---------------- response monitor ----------------
    int         resp_cnt = 0;
    int         busy_tot = 0;
    logic [7:0] resp_d = 8'h00;
    logic       resp_e = 1'b0;

    always @(negedge clk) begin
        if (hif.resp_valid) begin
            resp_cnt <= resp_cnt + 1;
            resp_d   <= hif.resp_data;
            resp_e   <= hif.resp_err;
        end
        if (hif.busy)
            busy_tot <= busy_tot + 1;
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_ready(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (hif.cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_resp(input int c0, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (resp_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] a, input logic [7:0] wd, output logic ok);
        @(negedge clk);
        hif.cmd_valid = 1'b1;
        hif.cmd_write = wr;
        hif.cmd_addr  = a;
        hif.cmd_wdata = wd;
        wait_ready(ok);
        @(negedge clk);
        hif.cmd_valid = 1'b0;
    endtask

    task automatic txn(input string tag, input logic wr, input logic [1:0] a, input logic [7:0] wd,
                       input logic [7:0] exp_d, input logic exp_e, input logic [7:0] exp_b1);
        logic ok;
        int   c0, r0, f0, b0, nb;
        c0 = resp_cnt; r0 = rise_tot; f0 = fall_tot; b0 = busy_tot;
        nb = wr ? WR_BYTES : 2;
        issue(wr, a, wd, ok);
        chk({tag, "_accept"}, 32'(ok), 32'd1);
        wait_resp(c0, ok);
        chk({tag, "_resp_seen"}, 32'(ok), 32'd1);
        @(negedge clk);
        chk({tag, "_resp_data"}, 32'(resp_d), 32'(exp_d));
        chk({tag, "_resp_err"}, 32'(resp_e), 32'(exp_e));
        chk({tag, "_resp_once"}, 32'(resp_cnt - c0), 32'd1);
        chk({tag, "_mosi0"}, 32'(mb[0]), 32'({wr, 5'b00000, a}));
        chk({tag, "_mosi1"}, 32'(mb[1]), 32'(exp_b1));
        chk({tag, "_rises"}, 32'(rise_tot - r0), 32'(8 * nb));
        chk({tag, "_falls"}, 32'(fall_tot - f0), 32'(8 * nb));
        chk({tag, "_busy_cyc"}, 32'(busy_tot - b0), 32'(wr ? WR_BUSY : RD_BUSY));
        $display("txn %s wr=%0d ch=%0d wdata=0x%02h -> resp=0x%02h err=%0d", tag, wr, a, wd, resp_d, resp_e);
    endtask

    initial begin
        logic ok;
        int   idle_bad;
        int   c0, nr;
        logic sp;

        hif.cmd_valid = 1'b0;
        hif.cmd_write = 1'b0;
        hif.cmd_addr  = 2'd0;
        hif.cmd_wdata = 8'h00;

        // reset state
        repeat (4) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_ready", 32'(hif.cmd_ready), 32'd0);
        chk("rst_resp", 32'({hif.resp_valid, hif.resp_err, hif.resp_data, hif.busy}), 32'd0);
        reset_n = 1'b1;

        // idle for 100 cycles
        idle_bad = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || hif.cmd_ready !== 1'b1)
                idle_bad++;
            @(negedge clk);
        end
        chk("idle_bad_cycles", 32'(idle_bad), 32'd0);
        chk("idle_no_resp", 32'(resp_cnt), 32'd0);

        txn("rd_ch1_rst", 1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 8'h00);
        txn("wr_ch2", 1'b1, 2'd2, 8'h5A, 8'h5A, 1'b0, 8'h5A);
        chk("model_lvl2", 32'(lvl[2]), 32'h5A);
        txn("rd_ch2", 1'b0, 2'd2, 8'h00, 8'h5A, 1'b0, 8'h00);
        txn("rd_ch0_wd_ignored", 1'b0, 2'd0, 8'hEE, 8'h00, 1'b0, 8'h00);

        // back-to-back writes with cmd_valid held
        c0 = resp_cnt;
        @(negedge clk);
        hif.cmd_valid = 1'b1;
        hif.cmd_write = 1'b1;
        hif.cmd_addr  = 2'd0;
        hif.cmd_wdata = 8'h01;
        wait_ready(ok);
        chk("b2b_accept0", 32'(ok), 32'd1);
        @(negedge clk);
        hif.cmd_addr  = 2'd3;
        hif.cmd_wdata = 8'hFF;
        wait_resp(c0, ok);
        chk("b2b_resp0", 32'(ok), 32'd1);
        wait_ready(ok);
        chk("b2b_accept1", 32'(ok), 32'd1);
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        wait_resp(c0 + 1, ok);
        chk("b2b_resp1", 32'(ok), 32'd1);
        @(negedge clk);
        chk("b2b_cs_gap_cycles", 32'(hi_last), 32'(CS_GAP * CLK_DIV));
        chk("b2b_resp_data1", 32'(resp_d), 32'hFF);
        chk("b2b_lvl0", 32'(lvl[0]), 32'h01);
        chk("b2b_lvl3", 32'(lvl[3]), 32'hFF);
        $display("txn b2b wr ch0=0x01, ch3=0xFF cs_n gap=%0d", hi_last);
        txn("rd_ch3", 1'b0, 2'd3, 8'h00, 8'hFF, 1'b0, 8'h00);

        // reset pulsed at the 5th rising sclk edge of a write
        c0 = resp_cnt;
        @(negedge clk);
        hif.cmd_valid = 1'b1;
        hif.cmd_write = 1'b1;
        hif.cmd_addr  = 2'd1;
        hif.cmd_wdata = 8'h33;
        wait_ready(ok);
        @(negedge clk);
        hif.cmd_valid = 1'b0;
        nr = 0;
        sp = sclk;
        for (int i = 0; i < 2000 && nr < 5; i++) begin
            @(negedge clk);
            if (sclk && !sp) nr++;
            sp = sclk;
        end
        chk("abort_5th_rise", 32'(nr), 32'd5);
        reset_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(cs_n), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(hif.busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (400) @(negedge clk);
        chk("abort_no_resp", 32'(resp_cnt - c0), 32'd0);
        chk("abort_lvl1", 32'(lvl[1]), 32'h00);
        $display("txn abort wr ch1=0x33 at rise %0d", nr);
        txn("rd_ch1_after_abort", 1'b0, 2'd1, 8'h00, 8'h00, 1'b0, 8'h00);

`ifdef SPI_PWM_WRITE_VERIFY_EN
        txn("vwr_ch0", 1'b1, 2'd0, 8'hC3, 8'hC3, 1'b0, 8'hC3);
        chk("vwr_byte3", 32'(mb[2]), 32'h00);
        force_zero = 1'b1;
        txn("vwr_ch0_fault", 1'b1, 2'd0, 8'hC3, 8'h00, 1'b1, 8'hC3);
        force_zero = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_pwm_host.md
Name: spi_pwm_host

Overview:
- SPI master that drives the 4-channel SPI PWM driver from the other end of its link.
- Converts a simple valid/ready command interface (read or write one PWM level) into the driver's byte protocol: MSB-first mosi, LSB-first miso, SPI mode 0, chip-select active-low.
- Sits in the host-side design on the same system clock domain class as the driver; the driver oversamples sclk, so sclk is slow and divided from clk.

Parameters:
- CLK_DIV, 8, clk cycles per sclk half-period; legal range 4..255 (covers driver edge-detect lag plus the 2-flop miso synchroniser).
- CS_GAP, 2, sclk half-periods of cs_n setup before the first edge, hold after the last edge, and minimum high time between transactions.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write level, 0 = read level.
- cmd_addr  in  2  channel 0..3.
- cmd_wdata  in  8  level to write.
- resp_valid  out  1  one-cycle pulse when a transaction completes.
- resp_data  out  8  read level, or write echo; held until the next resp_valid.
- resp_err  out  1  write-echo mismatch; valid with resp_valid.
- busy  out  1  high from accept until resp_valid.
- sclk  out  1  SPI clock, idle low.
- cs_n  out  1  chip select, active-low, idle high.
- mosi  out  1  master out.
- miso  in  1  slave out; 2-flop synchronised internally.

Behaviour:
- Reset (async assert, sync release): cs_n=1, sclk=0, mosi=0, cmd_ready=0 during reset then 1, resp_valid=0, resp_data=0, resp_err=0, busy=0, FSM=IDLE.
- Command byte format:
  - write: {1,00000,addr}.
  - read: {000000,addr}.
- Read transaction, 2 bytes: cmd, then 0x00.
  - Captured miso bits during byte 2 are assembled LSB first; bit i is sampled at the i-th rising edge of byte 2.
  - resp_data = assembled byte; resp_err=0.
- Write transaction, 2 bytes (feature off): cmd, then wdata. resp_data=wdata, resp_err=0.
- FSM states: IDLE -> CS_SETUP (cs_n=0, CS_GAP half-periods) -> SHIFT_LO -> SHIFT_HI (alternating, each CLK_DIV cycles) -> CS_HOLD (CS_GAP half-periods, sclk low) -> CS_GAP (cs_n=1, CS_GAP half-periods) -> IDLE.
- Bit and byte sequencing:
  - 3-bit bit counter and 2-bit byte counter.
  - After the 8th SHIFT_HI of the last byte, the FSM goes through one final SHIFT_LO (sclk falls) and then into CS_HOLD. This falling edge is required for the driver to commit a write.
- mosi timing:
  - mosi updates at entry to SHIFT_LO, MSB first.
  - mosi is stable for the whole high phase.
  - mosi=0 outside transfers.
- miso sampling: the synchronised miso is sampled in the cycle sclk is driven high, i.e. the end of SHIFT_LO.
- Handshake and result timing:
  - The accept cycle latches cmd_write, cmd_addr and cmd_wdata.
  - cmd_ready=0 from accept until IDLE is re-entered.
  - resp_valid pulses in the cycle CS_GAP is entered, i.e. the same cycle cs_n rises.
- Total transaction length: (2*CS_GAP + 2*8*nbytes + 1)*CLK_DIV + CS_GAP*CLK_DIV cycles.
- Boundary behaviour:
  - cmd_valid held high continuously gives back-to-back transactions separated by exactly CS_GAP half-periods of cs_n high.
  - cmd_addr is used modulo 4; no illegal values exist.
  - Reset asserted mid-transaction: cs_n returns high immediately, so the driver aborts. A partial write without its final falling edge is not committed. No resp_valid is issued.
  - miso changing during the high phase is ignored.

Optional Feature:
- SPI_PWM_WRITE_VERIFY_EN
- Defined:
  - A write becomes 3 bytes: cmd, wdata, 0x00.
  - The echo is captured LSB first during byte 3 into resp_data.
  - resp_err = (echo != wdata).
- Undefined: writes are 2 bytes, and resp_err is constant 0.

Test Plan:
- Reset then idle, with no command for 100 cycles -> cs_n=1, sclk=0, mosi=0, cmd_ready=1, resp_valid never pulses.
- Write ch2=0x5A with CLK_DIV=8 -> mosi carries 0x82 then 0x5A MSB first on rising edges; 16 rising plus 16 falling edges; resp_valid pulses once with resp_data=0x5A; a driver model reports level[2]=0x5A.
- Read ch2 after the previous write -> mosi 0x02, 0x00; resp_data=0x5A.
- Read ch1 after reset -> resp_data=0x00.
- Back-to-back writes ch0=0x01 and ch3=0xFF with cmd_valid held -> cs_n high for exactly 2*CLK_DIV cycles between transactions; a subsequent read of ch3 returns 0xFF.
- reset_n pulsed low at the 5th rising edge of a write ch1=0x33 -> cs_n=1 the same cycle, no resp_valid, the driver keeps level[1]=0x00.
- With SPI_PWM_WRITE_VERIFY_EN, write ch0=0xC3 -> 24 rising edges, resp_data=0xC3, resp_err=0; with a fault model forcing miso=0 -> resp_err=1.
